alu_control: RTL and testbench



---
 rtl/alu_control_pkg.sv | 31 +++
 rtl/alu_control_sync2.sv | 32 +++
 rtl/alu_control.sv | 151 +++++++++++++++
 tb/tb_alu_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_pkg.sv
// ---------------------------------------------------------------------------
// alu_control_pkg
// Shared definitions for the ALU operation sequencer: the opcode set (also
// used by the ALU top level), the sequencer state encoding and a helper that
// turns an opcode into the one-hot unit enable.
// ---------------------------------------------------------------------------
package alu_control_pkg;

  localparam int NUM_UNITS = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    OP_SUMA  = 2'd0,
    OP_RESTA = 2'd1,
    OP_MULT  = 2'd2,
    OP_COMPL = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [NUM_UNITS-1:0] op_onehot(input opcode_e op);
    return NUM_UNITS'(1) << op;
  endfunction

endpackage

// File: rtl/alu_control_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single level signal coming from another
// timing domain. Both flops reset asynchronously to 0.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input level
//   q   : synchronized level, two clk cycles behind d
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: state is updated with non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain
  // into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alu_control.sv
// ---------------------------------------------------------------------------
// alu_control
// Sequencer for the ALU operation units (suma, resta, multiplicacion,
// complemento). One request is accepted at a time: operands are presented,
// then a level-held one-hot enable is raised to the selected unit. After the
// unit's done flag is seen the enable is dropped and the sequencer waits for
// done to clear before returning the captured result with a one-cycle valid.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request strobe, only looked at while idle
//   opcode       : 0 suma, 1 resta, 2 multiplicacion, 3 complemento
//   data_in      : packed operands, A = upper WIDTH bits, B = lower WIDTH bits
//   unit_data    : latched operands, shared by all units
//   unit_en      : one-hot enable, bit n selects opcode n
//   unit_done    : done flags from the units (asynchronous)
//   unit_result  : unit results, slice n = [n*2*WIDTH +: 2*WIDTH]
//   result       : last captured result, held until the next capture
//   valid        : one-cycle pulse when result is new
//   busy         : high whenever the sequencer is not idle
//   error        : one-cycle pulse when a handshake phase times out
// ---------------------------------------------------------------------------
module alu_control
  import alu_control_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15   // cycles allowed in each of WAIT and RELEASE (1..255)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     opcode,
  input  logic [2*WIDTH-1:0]             data_in,
  output logic [2*WIDTH-1:0]             unit_data,
  output logic [NUM_UNITS-1:0]           unit_en,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  logic [NUM_UNITS*2*WIDTH-1:0]   unit_result,
  output logic [2*WIDTH-1:0]             result,
  output logic                           valid,
  output logic                           busy,
  output logic                           error
);

  localparam int DW = 2 * WIDTH;

  logic [NUM_UNITS-1:0] done_s;
  logic [DW-1:0]        res_arr [NUM_UNITS];

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (unit_done[i]),
      .q   (done_s[i])
    );
    assign res_arr[i] = unit_result[i*DW +: DW];
  end

  state_e           state;
  opcode_e          op_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [DW-1:0]    cap_q;

  // Only the selected unit's flag matters; the others are don't-care.
  logic done_sel;
  assign done_sel = done_s[op_q];

  // The abort is decided one cycle early so that error and the enable drop
  // become visible exactly TIMEOUT cycles after the phase was entered.
  logic tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_SUMA;
      tmo_cnt   <= '0;
      cap_q     <= '0;
      unit_data <= '0;
      unit_en   <= '0;
      result    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // Pulses default low and are raised only in the cycle that needs them.
      valid <= 1'b0;
      error <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= opcode_e'(opcode);
            unit_data <= data_in;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        // Operands have been stable for a cycle before the enable rises.
        ST_ISSUE: begin
          unit_en <= op_onehot(op_q);
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end

        // A done flag already high on entry counts as done.
        ST_WAIT: begin
          if (done_sel) begin
            cap_q   <= res_arr[op_q];
            unit_en <= '0;
            tmo_cnt <= '0;
            state   <= ST_RELEASE;
          end else if (tmo_hit) begin
            unit_en <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (!done_sel) begin
            state <= ST_DONE;
          end else if (tmo_hit) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          result <= cap_q;
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          unit_en <= '0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// ---------------------------------------------------------------------------
// tb_alu_control
// Self-checking bench for alu_control. The operation units are modelled by
// arithmetic on the operands plus a done flag that rises a cycles after the
// enable rises and falls b cycles after it falls. Expected per-cycle outputs
// come from the handshake timing rules: enable at cycle 2, done seen two
// cycles after it changes, enable drop one cycle later, valid two cycles after
// the clear is seen, and a TIMEOUT-cycle limit on each handshake phase.
// ---------------------------------------------------------------------------
module tb_alu_control;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int DW      = 2 * WIDTH;
  localparam int NEVER   = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      opcode;
  logic [DW-1:0]   data_in;
  logic [DW-1:0]   unit_data;
  logic [3:0]      unit_en;
  logic [3:0]      unit_done;
  logic [4*DW-1:0] unit_result;
  logic [DW-1:0]   result;
  logic            valid;
  logic            busy;
  logic            error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_res_q;

  always #5 clk = ~clk;

  alu_control #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .data_in     (data_in),
    .unit_data   (unit_data),
    .unit_en     (unit_en),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .result      (result),
    .valid       (valid),
    .busy        (busy),
    .error       (error)
  );

  // Unit arithmetic: narrow results are zero-extended to DW bits.
  function automatic logic [DW-1:0] unit_fn(input int op, input logic [DW-1:0] d);
    int ua;
    int ub;
    int mask;
    ua   = int'(d[DW-1:WIDTH]);
    ub   = int'(d[WIDTH-1:0]);
    mask = (1 << WIDTH) - 1;
    case (op)
      0:       return DW'(ua + ub);
      1:       return DW'((ua - ub) & mask);
      2:       return DW'(ua * ub);
      default: return DW'(~ua & mask);
    endcase
  endfunction

  always_comb begin
    unit_result = '0;
    for (int n = 0; n < 4; n++) unit_result[n*DW +: DW] = unit_fn(n, unit_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete request. a/b: unit done delays; intr: cycle of an extra
  // start pulse (opcode 1) that must be ignored, 0 for none.
  task automatic run_op(input int op, input logic [DW-1:0] d, input int a, input int b,
                        input int intr, output logic saw_err);
    int   f;
    int   end_c;
    int   en_end;
    int   rise;
    int   fall;
    bit   success;
    logic [3:0]    onehot;
    logic [3:0]    exp_en;
    logic [DW-1:0] exp_res;
    logic [DW-1:0] new_res;

    onehot  = 4'b0001 << op;
    new_res = unit_fn(op, d);
    saw_err = 1'b0;
    rise    = -1;
    fall    = -1;

    // Event timeline relative to the cycle start is sampled (cycle 0).
    if (a + 2 <= TIMEOUT - 1) begin
      f      = 2 + a + 3;
      en_end = f;
      if (b + 2 <= TIMEOUT - 1) begin
        success = 1'b1;
        end_c   = f + b + 4;
      end else begin
        success = 1'b0;
        end_c   = f + TIMEOUT;
      end
    end else begin
      success = 1'b0;
      end_c   = 2 + TIMEOUT;
      en_end  = end_c;
    end

    @(posedge clk); #1;
    start   = 1'b1;
    opcode  = 2'(op);
    data_in = d;
    check($sformatf("op%0d c0 busy", op), 32'(busy), 32'd0);

    for (int c = 1; c <= end_c + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start   = 1'b0;
        opcode  = 2'($urandom);
        data_in = DW'($urandom);
      end
      if (intr != 0 && c == intr) begin
        start   = 1'b1;
        opcode  = 2'd1;
        data_in = DW'($urandom);
      end
      if (intr != 0 && c == intr + 1) start = 1'b0;

      exp_en  = (c >= 2 && c < en_end) ? onehot : 4'b0000;
      exp_res = (success && c >= end_c) ? new_res : exp_res_q;
      check($sformatf("op%0d c%0d unit_en", op, c), 32'(unit_en), 32'(exp_en));
      check($sformatf("op%0d c%0d busy", op, c), 32'(busy), 32'(c < end_c));
      check($sformatf("op%0d c%0d valid", op, c), 32'(valid), 32'(success && c == end_c));
      check($sformatf("op%0d c%0d error", op, c), 32'(error), 32'(!success && c == end_c));
      check($sformatf("op%0d c%0d result", op, c), 32'(result), 32'(exp_res));
      check($sformatf("op%0d c%0d unit_data", op, c), 32'(unit_data), 32'(d));
      if (error) saw_err = 1'b1;

      // Unit model reacts to the enable it actually sees.
      if (unit_en[op] && rise < 0) rise = c;
      if (!unit_en[op] && rise >= 0 && fall < 0) fall = c;
      unit_done[op] = (rise >= 0 && c >= rise + a) && !(fall >= 0 && c >= fall + b);
    end

    if (success) exp_res_q = new_res;
    unit_done = '0;
    repeat (4) @(posedge clk);
  endtask

  typedef struct {
    int          op;
    logic [7:0]  data;
    int          a;
    int          b;
    int          intr;
    logic [7:0]  exp_result;
    logic        exp_error;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    int   cnt;

    rst       = 1'b1;
    start     = 1'b0;
    opcode    = '0;
    data_in   = '0;
    unit_done = '0;
    exp_res_q = '0;

    repeat (2) @(posedge clk); #1;
    check("reset unit_en", 32'(unit_en), 32'd0);
    check("reset unit_data", 32'(unit_data), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset error", 32'(error), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // op, data, a, b, intr, expected result, expected error
    tbl[0] = '{0, 8'h35, 1,     1,     4, 8'h08, 1'b0};  // suma, ignored start in WAIT
    tbl[1] = '{3, 8'hA0, 1,     1,     0, 8'h05, 1'b0};  // complemento
    tbl[2] = '{2, 8'hF7, NEVER, 0,     0, 8'h05, 1'b1};  // no done: WAIT timeout
    tbl[3] = '{1, 8'h73, 0,     0,     6, 8'h04, 1'b0};  // fastest unit
    tbl[4] = '{0, 8'hFF, 12,    12,    0, 8'h1E, 1'b0};  // last cycle before timeout
    tbl[5] = '{1, 8'h35, 13,    0,     0, 8'h1E, 1'b1};  // one cycle too late
    tbl[6] = '{2, 8'hF7, 2,     NEVER, 0, 8'h1E, 1'b1};  // stuck done: RELEASE timeout
    tbl[7] = '{2, 8'hF7, 0,     3,     0, 8'h69, 1'b0};

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].data, tbl[i].a, tbl[i].b, tbl[i].intr, saw);
      check($sformatf("row%0d result", i), 32'(result), 32'(tbl[i].exp_result));
      check($sformatf("row%0d error seen", i), 32'(saw), 32'(tbl[i].exp_error));
    end

    // Reset while resta is waiting on its unit.
    @(posedge clk); #1;
    start   = 1'b1;
    opcode  = 2'd1;
    data_in = 8'h73;
    @(posedge clk); #1;
    start = 1'b0;
    cnt   = 0;
    while (!unit_en[1] && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("rstseq unit_en before reset", 32'(unit_en), 32'b0010);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("rstseq unit_en", 32'(unit_en), 32'd0);
    check("rstseq unit_data", 32'(unit_data), 32'd0);
    check("rstseq result", 32'(result), 32'd0);
    check("rstseq valid", 32'(valid), 32'd0);
    check("rstseq busy", 32'(busy), 32'd0);
    check("rstseq error", 32'(error), 32'd0);
    #1 rst = 1'b0;
    exp_res_q = '0;
    repeat (3) @(posedge clk);
    run_op(1, 8'h73, 1, 1, 0, saw);
    check("rstseq next result", 32'(result), 32'h04);
    check("rstseq next error", 32'(saw), 32'd0);

    // Randomized requests, including timeouts on either phase.
    for (int i = 0; i < 30; i++) begin
      int op_r;
      int a_r;
      int b_r;
      int intr_r;
      op_r   = int'($urandom_range(0, 3));
      a_r    = int'($urandom_range(0, 14));
      b_r    = int'($urandom_range(0, 14));
      intr_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : 0;
      run_op(op_r, DW'($urandom), a_r, b_r, intr_r, saw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
